// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory slave with independent read/write FSMs, 64-bit beats.
// Define AXI_MEM_SLAVE_STALL_EN to enable LFSR-driven WREADY/RVALID stalls.
module axi_mem_slave #(
    parameter int                    AXI_ID_W   = 1,
    parameter int                    AXI_ADDR_W = 32,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [AXI_ID_W-1:0]   S_AXI_AWID,
    input  logic [AXI_ADDR_W-1:0] S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [63:0]           S_AXI_WDATA,
    input  logic [7:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [AXI_ID_W-1:0]   S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [AXI_ID_W-1:0]   S_AXI_ARID,
    input  logic [AXI_ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [AXI_ID_W-1:0]   S_AXI_RID,
    output logic [63:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [AXI_ADDR_W-1:0] ALIGN = ~AXI_ADDR_W'(7);
    localparam logic [AXI_ADDR_W-1:0] BEAT  = AXI_ADDR_W'(8);
    localparam logic [AXI_ADDR_W-1:0] DEPTH = AXI_ADDR_W'(MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [63:0] mem [MEM_WORDS];

    logic stall;

`ifdef AXI_MEM_SLAVE_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // ---------------- write path ----------------
    w_state_t              w_state;
    logic                  awready_q;
    logic                  w_en;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [AXI_ID_W-1:0]   bid_q;
    logic [AXI_ID_W-1:0]   w_id;
    logic [AXI_ADDR_W-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic                  w_decerr;
    logic                  w_slverr;

    logic [AXI_ADDR_W-1:0] w_word;
    logic                  w_in;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_fire;
    logic                  w_final;
    logic                  beat_dec;
    logic                  beat_slv;
    logic                  w_we;

    assign w_word   = (w_addr - BASE_ADDR) >> 3;
    assign w_in     = (w_addr >= BASE_ADDR) && (w_word < DEPTH);
    assign w_idx    = w_word[IDX_W-1:0];
    assign w_fire   = S_AXI_WVALID && S_AXI_WREADY;
    assign w_final  = (w_cnt == w_len);
    assign beat_dec = w_decerr | ~w_in;
    assign beat_slv = w_slverr | (S_AXI_WLAST != w_final);
    assign w_we     = w_fire && w_in;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            w_en      <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            w_id      <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_decerr  <= 1'b0;
            w_slverr  <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (S_AXI_AWVALID && awready_q) begin
                        w_id      <= S_AXI_AWID;
                        w_addr    <= S_AXI_AWADDR & ALIGN;
                        w_len     <= S_AXI_AWLEN;
                        w_cnt     <= '0;
                        w_decerr  <= 1'b0;
                        w_slverr  <= 1'b0;
                        awready_q <= 1'b0;
                        w_en      <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_decerr <= beat_dec;
                        w_slverr <= beat_slv;
                        if (w_final) begin
                            w_en     <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= w_id;
                            bresp_q  <= beat_dec ? RESP_DECERR :
                                        beat_slv ? RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= w_addr + BEAT;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int b = 0; b < 8; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = w_en & ~stall;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = bid_q;

    // ---------------- read path ----------------
    r_state_t              r_state;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [63:0]           rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic [AXI_ID_W-1:0]   rid_q;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;

    logic                  r_idle;
    logic                  ar_fire;
    logic                  r_fire;
    logic [AXI_ADDR_W-1:0] ld_addr;
    logic [7:0]            ld_cnt;
    logic [7:0]            ld_len;
    logic [AXI_ADDR_W-1:0] ld_word;
    logic                  ld_in;
    logic [IDX_W-1:0]      ld_idx;
    logic [63:0]           ld_data;
    logic                  ld_en;

    assign r_idle  = (r_state == R_IDLE);
    assign ar_fire = r_idle && S_AXI_ARVALID && arready_q;
    assign r_fire  = rvalid_q && S_AXI_RREADY;

    // Address/count of the beat that would be loaded into the R registers now.
    assign ld_addr = r_idle ? (S_AXI_ARADDR & ALIGN) :
                     r_fire ? (r_addr + BEAT) : r_addr;
    assign ld_cnt  = r_idle ? 8'd0 : r_fire ? (r_cnt + 8'd1) : r_cnt;
    assign ld_len  = r_idle ? S_AXI_ARLEN : r_len;
    assign ld_word = (ld_addr - BASE_ADDR) >> 3;
    assign ld_in   = (ld_addr >= BASE_ADDR) && (ld_word < DEPTH);
    assign ld_idx  = ld_word[IDX_W-1:0];
    assign ld_data = ld_in ? mem[ld_idx] : 64'h0;

    assign ld_en = ar_fire ||
                   (!r_idle && !stall && (r_fire ? !rlast_q : !rvalid_q));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        r_id      <= S_AXI_ARID;
                        r_addr    <= ld_addr;
                        r_len     <= S_AXI_ARLEN;
                        r_cnt     <= ld_cnt;
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire && rlast_q) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end else if (r_fire) begin
                        r_addr <= ld_addr;
                        r_cnt  <= ld_cnt;
                        if (stall) begin
                            rvalid_q <= 1'b0;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
            if (ld_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= ld_data;
                rresp_q  <= ld_in ? RESP_OKAY : RESP_DECERR;
                rlast_q  <= (ld_cnt == ld_len);
                rid_q    <= r_idle ? S_AXI_ARID : r_id;
            end
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = rid_q;

endmodule
